screen_sequencer: RTL
=====================

SCREEN_SEQUENCER -- requirements
Module: screen_sequencer

Interface
REQ-001 Parameter HOLD_FRAMES, default 120: minimum frames WIN/LOSE stays up before start is accepted.
REQ-002 Parameter TIMEOUT_FRAMES, default 600: frames after which WIN/LOSE returns to TITLE unprompted.
REQ-003 clk  input  1  system clock; the only clock in the block.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 video_on  input  1  display-active flag from the VGA sync generator.
REQ-006 pixel_x, pixel_y  input  11 each  current pixel coordinates from the VGA sync generator.
REQ-007 start_btn  input  1  debounced level of the start button.
REQ-008 aliens_cleared  input  1  single-cycle pulse from the game core: the last alien is destroyed.
REQ-009 player_dead  input  1  single-cycle pulse from the game core: the last life is lost.
REQ-010 title_rgb, game_rgb, win_rgb, lose_rgb  input  5 each  colour from each screen renderer.
REQ-011 vga_rgb  output  5  selected pixel colour, registered.
REQ-012 frame_count  output  28  free-running clock-cycle counter that drives screen animation.
REQ-013 screen_sel  output  2  current state: 0 TITLE, 1 PLAY, 2 WIN, 3 LOSE.
REQ-014 game_run  output  1  high only while in PLAY.
REQ-015 game_restart  output  1  single-cycle pulse on every TITLE->PLAY transition.

Function
REQ-016 frame_count: increments by 1 every clk; wraps from 2^28-1 to 0.
REQ-017 frame_tick (internal): one-cycle pulse on the first clk where (pixel_x,pixel_y)==(0,0) after any other coordinate pair.
- Exactly one tick per frame, even when pixel (0,0) is held for several clk cycles.
REQ-018 start_press (internal): rising edge of start_btn, one cycle wide.
- A button held high through reset does not generate a press.
REQ-019 States TITLE, PLAY, WIN, LOSE; encoding as in REQ-013.
REQ-020 TITLE->PLAY on start_press; game_restart pulses in the same cycle the state register changes.
REQ-021 PLAY->LOSE on player_dead; PLAY->WIN on aliens_cleared.
- If both pulse in the same cycle, LOSE wins.
REQ-022 aliens_cleared and player_dead are ignored in every state other than PLAY.
REQ-023 WIN/LOSE: a frame counter (dwell) clears on entry and increments on each frame_tick, saturating at TIMEOUT_FRAMES.
REQ-024 WIN/LOSE->TITLE on start_press only when dwell >= HOLD_FRAMES; earlier presses are discarded, not queued.
REQ-025 WIN/LOSE->TITLE automatically in the cycle after dwell reaches TIMEOUT_FRAMES.
REQ-026 start_press in PLAY has no effect.
REQ-027 vga_rgb: registered mux, one-cycle latency from the *_rgb inputs.
- Source: title_rgb, game_rgb, win_rgb or lose_rgb per screen_sel.
- Output is 5'b00000 whenever the registered video_on is 0.
REQ-028 On a state change, vga_rgb switches source from the next clk onward; no blanking frame is inserted.
REQ-029 game_run = (state == PLAY); registered, changes in the same cycle as screen_sel.

Reset
REQ-030 A synchronous reset wins over every other event in the same cycle, including mid-frame and mid-WIN/LOSE.
REQ-031 Values after reset:
- state TITLE, screen_sel 0
- vga_rgb 0, frame_count 0
- game_run 0, game_restart 0
- dwell 0
- frame_tick and start_press history cleared: start_btn previous value treated as 1; pixel history treated as (0,0)

Structure
REQ-032 The shared package holds:
- state encoding constants TITLE/PLAY/WIN/LOSE
- COLOR_BLACK = 5'b00000
- SCREEN_WIDTH 640, SCREEN_HEIGHT 480
REQ-033 Edge/tick generation is one sub-module, frame_tick_gen, holding the frame_tick and start_press detectors; the state machine and colour mux stay in screen_sequencer.

Verification
REQ-034 Reset then start_btn 0->1 -> game_restart high for 1 cycle, screen_sel 1, game_run 1.
REQ-035 In PLAY, aliens_cleared and player_dead pulse in the same cycle -> screen_sel 3 next cycle; game_run 0.
REQ-036 HOLD_FRAMES=4: in WIN, press after 2 frame_ticks -> stays in WIN; press after 4 ticks -> screen_sel 0.
REQ-037 TIMEOUT_FRAMES=6, no press -> in LOSE, screen_sel 0 one cycle after the 6th frame_tick.
REQ-038 video_on=0 with win_rgb=5'b11111 in WIN -> vga_rgb 0; video_on=1 -> vga_rgb 5'b11111 one cycle later.
REQ-039 Reset asserted in WIN with dwell=3 and (pixel_x,pixel_y) held at (0,0) for 5 clks -> screen_sel 0; frame_count 0; no frame_tick until the coordinates leave (0,0) and return.

Source files
------------

// File: rtl/screen_sequencer_pkg.sv
// Shared types and constants for the screen sequencer: screen encoding,
// bus widths and display geometry.
package screen_sequencer_pkg;

  localparam int unsigned RGB_W       = 5;
  localparam int unsigned COORD_W     = 11;
  localparam int unsigned FRAME_CNT_W = 28;

  localparam int unsigned SCREEN_WIDTH  = 640;
  localparam int unsigned SCREEN_HEIGHT = 480;

  localparam logic [RGB_W-1:0] COLOR_BLACK = 5'b00000;

  typedef enum logic [1:0] {
    TITLE = 2'd0,
    PLAY  = 2'd1,
    WIN   = 2'd2,
    LOSE  = 2'd3
  } screen_e;

  // WIN and LOSE share the dwell / timeout behaviour.
  function automatic logic is_end_screen(input screen_e s);
    return (s == WIN) || (s == LOSE);
  endfunction

endpackage

// File: rtl/screen_sequencer_frame_tick_gen.sv
// Edge detectors feeding the sequencer: one pulse per video frame and one
// pulse per start-button press.
module frame_tick_gen
  import screen_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic               start_btn,
  output logic               frame_tick_c,
  output logic               start_press_c
);

  logic at_origin_c;
  logic origin_prev;
  logic start_prev;

  assign at_origin_c = (pixel_x == '0) && (pixel_y == '0);

  // History resets to "at origin" and "button high" so neither a held
  // origin nor a held button fires right after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      origin_prev <= 1'b1;
      start_prev  <= 1'b1;
    end else begin
      origin_prev <= at_origin_c;
      start_prev  <= start_btn;
    end
  end

  assign frame_tick_c  = at_origin_c && !origin_prev;
  assign start_press_c = start_btn && !start_prev;

endmodule

// File: rtl/screen_sequencer.sv
// Game screen state machine (TITLE/PLAY/WIN/LOSE) with end-screen dwell
// timing and a registered per-screen colour mux.
module screen_sequencer
  import screen_sequencer_pkg::*;
#(
  parameter int unsigned HOLD_FRAMES    = 120,
  parameter int unsigned TIMEOUT_FRAMES = 600
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   video_on,
  input  logic [COORD_W-1:0]     pixel_x,
  input  logic [COORD_W-1:0]     pixel_y,
  input  logic                   start_btn,
  input  logic                   aliens_cleared,
  input  logic                   player_dead,
  input  logic [RGB_W-1:0]       title_rgb,
  input  logic [RGB_W-1:0]       game_rgb,
  input  logic [RGB_W-1:0]       win_rgb,
  input  logic [RGB_W-1:0]       lose_rgb,
  output logic [RGB_W-1:0]       vga_rgb,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic [1:0]             screen_sel,
  output logic                   game_run,
  output logic                   game_restart
);

  localparam int unsigned DWELL_W = $clog2(TIMEOUT_FRAMES + 1);

  screen_e            state_q;
  screen_e            state_d;
  logic [DWELL_W-1:0] dwell_q;
  logic               frame_tick_c;
  logic               start_press_c;
  logic               dwell_done_c;
  logic               hold_met_c;
  logic               game_run_d;
  logic               game_restart_d;
  logic [RGB_W-1:0]   rgb_sel_c;

  frame_tick_gen u_tick_gen (
    .clk           (clk),
    .reset         (reset),
    .pixel_x       (pixel_x),
    .pixel_y       (pixel_y),
    .start_btn     (start_btn),
    .frame_tick_c  (frame_tick_c),
    .start_press_c (start_press_c)
  );

  assign dwell_done_c = (32'(dwell_q) == TIMEOUT_FRAMES);
  assign hold_met_c   = (32'(dwell_q) >= HOLD_FRAMES);

  // State and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= TITLE;
      game_run     <= 1'b0;
      game_restart <= 1'b0;
    end else begin
      state_q      <= state_d;
      game_run     <= game_run_d;
      game_restart <= game_restart_d;
    end
  end

  // Next-state; a simultaneous death and clear resolves to LOSE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TITLE: if (start_press_c) state_d = PLAY;
      PLAY: begin
        if (player_dead)         state_d = LOSE;
        else if (aliens_cleared) state_d = WIN;
      end
      WIN, LOSE: begin
        if (dwell_done_c || (start_press_c && hold_met_c)) state_d = TITLE;
      end
      default: state_d = TITLE;
    endcase
  end

  // Output decode, registered alongside the state.
  always_comb begin
    game_run_d     = 1'b0;
    game_restart_d = 1'b0;
    rgb_sel_c      = title_rgb;
    game_run_d     = (state_d == PLAY);
    game_restart_d = (state_q == TITLE) && (state_d == PLAY);
    case (state_q)
      TITLE:   rgb_sel_c = title_rgb;
      PLAY:    rgb_sel_c = game_rgb;
      WIN:     rgb_sel_c = win_rgb;
      LOSE:    rgb_sel_c = lose_rgb;
      default: rgb_sel_c = title_rgb;
    endcase
  end

  // Dwell restarts on every state change and only counts on end screens.
  always_ff @(posedge clk) begin
    if (reset || (state_d != state_q) || !is_end_screen(state_q)) begin
      dwell_q <= '0;
    end else if (frame_tick_c && !dwell_done_c) begin
      dwell_q <= dwell_q + DWELL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vga_rgb     <= COLOR_BLACK;
      frame_count <= '0;
    end else begin
      vga_rgb     <= video_on ? rgb_sel_c : COLOR_BLACK;
      frame_count <= frame_count + FRAME_CNT_W'(1);
    end
  end

  assign screen_sel = state_q;

endmodule
